// File: rtl/gray_ss_rx.sv
// rtl/gray_ss_rx.sv - serial 2-bit Gray stream receiver with decoded-word history
module gray_ss_rx #(
  parameter int HIST_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          ss_valid,
  input  logic                          ss_start,
  input  logic [1:0]                    ss,
  output logic [31:0]                   dataout,
  output logic                          dout_valid,
  output logic                          frame_err,
  output logic                          busy,
  input  logic                          rw,
  input  logic [$clog2(HIST_DEPTH)-1:0] addr,
  output logic [31:0]                   rd_data
);

  localparam int AW = $clog2(HIST_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_DECODE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [31:0]   g_q, g_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [31:0]   dataout_q, dataout_d;
  logic          dout_valid_q, dout_valid_d;
  logic          frame_err_q, frame_err_d;
  logic [31:0]   rd_data_q, rd_data_d;
  logic [31:0]   hist_q [HIST_DEPTH];
  logic [31:0]   hist_d [HIST_DEPTH];

  logic [31:0]   bin;
  logic          hist_we;
  logic [4:0]    bit_hi;

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [31:0] gray_to_bin(input logic [31:0] gv);
    logic [31:0] bv;
    bv[31] = gv[31];
    for (int i = 30; i >= 0; i--) begin
      bv[i] = bv[i+1] ^ gv[i];
    end
    return bv;
  endfunction

  // Frame sequencing: collect 16 beats MSB pair first, decode for one cycle, publish.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    g_d          = g_q;
    wptr_d       = wptr_q;
    dataout_d    = dataout_q;
    dout_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    hist_we      = 1'b0;
    bin          = gray_to_bin(g_q);
    // Beat k lands at bits [31-2k:30-2k], so the pair's upper bit index is 31-2*cnt.
    bit_hi       = 5'd31 - {cnt_q, 1'b0};

    case (state_q)
      ST_IDLE: begin
        // Stray non-start beats are simply ignored while idle.
        if (ss_valid && ss_start) begin
          g_d     = {ss, 30'b0};
          cnt_d   = 4'd1;
          state_d = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        if (ss_valid) begin
          if (ss_start) begin
            // A new start mid-frame abandons the partial word and restarts from this beat.
            frame_err_d = 1'b1;
            g_d         = {ss, 30'b0};
            cnt_d       = 4'd1;
          end else begin
            g_d[bit_hi -: 2] = ss;
            cnt_d            = cnt_q + 4'd1;
            if (cnt_q == 4'd15) begin
              state_d = ST_DECODE;
            end
          end
        end
      end

      ST_DECODE: begin
        dataout_d    = bin;
        dout_valid_d = 1'b1;
        hist_we      = 1'b1;
        wptr_d       = wptr_q + AW'(1);
        state_d      = ST_IDLE;
        // No beat can be taken while decoding; report the loss instead of starting a frame.
        if (ss_valid) begin
          frame_err_d = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // History write port and registered read port (read sees pre-write contents).
  always_comb begin
    hist_d = hist_q;
    if (hist_we) begin
      hist_d[wptr_q] = bin;
    end
    rd_data_d = rw ? hist_q[addr] : rd_data_q;
  end

  // Control, datapath and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 4'd0;
      g_q          <= 32'd0;
      wptr_q       <= '0;
      dataout_q    <= 32'd0;
      dout_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      rd_data_q    <= 32'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      g_q          <= g_d;
      wptr_q       <= wptr_d;
      dataout_q    <= dataout_d;
      dout_valid_q <= dout_valid_d;
      frame_err_q  <= frame_err_d;
      rd_data_q    <= rd_data_d;
    end
  end

  // History storage, cleared entirely by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < HIST_DEPTH; i++) begin
        hist_q[i] <= 32'd0;
      end
    end else begin
      hist_q <= hist_d;
    end
  end

  assign dataout    = dataout_q;
  assign dout_valid = dout_valid_q;
  assign frame_err  = frame_err_q;
  assign rd_data    = rd_data_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_gray_ss_rx.sv
// tb/tb_gray_ss_rx.sv - self-checking bench for gray_ss_rx
module tb_gray_ss_rx;

  localparam int HIST_DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ss_valid = 1'b0;
  logic        ss_start = 1'b0;
  logic [1:0]  ss = 2'b00;
  logic        rw = 1'b0;
  logic [1:0]  addr = 2'b00;
  logic [31:0] dataout;
  logic        dout_valid;
  logic        frame_err;
  logic        busy;
  logic [31:0] rd_data;

  int checks = 0;
  int errors = 0;
  int dv_cnt = 0;
  int fe_cnt = 0;

  gray_ss_rx #(.HIST_DEPTH(HIST_DEPTH)) dut (
    .clk(clk), .reset(reset), .ss_valid(ss_valid), .ss_start(ss_start), .ss(ss),
    .dataout(dataout), .dout_valid(dout_valid), .frame_err(frame_err), .busy(busy),
    .rw(rw), .addr(addr), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Gray to binary by prefix XOR with doubling shifts.
  function automatic logic [31:0] m_g2b(input logic [31:0] gv);
    logic [31:0] bv;
    bv = gv;
    for (int s = 1; s < 32; s = s * 2) bv = bv ^ (bv >> s);
    return bv;
  endfunction

  // Reference model: queue of accepted symbols; 16 queued symbols means decode pending.
  logic [1:0]  mq[$];
  logic [31:0] mhist [HIST_DEPTH];
  int          mw = 0;
  logic [31:0] exp_dout = 0, exp_rd = 0;
  logic        exp_dv = 0, exp_fe = 0, exp_busy = 0;

  initial begin
    logic [31:0] gw;
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        mq.delete();
        exp_dout = 0; exp_dv = 0; exp_fe = 0; exp_rd = 0; mw = 0;
        for (int i = 0; i < HIST_DEPTH; i++) mhist[i] = 0;
      end else begin
        exp_dv = 0;
        exp_fe = 0;
        if (rw) exp_rd = mhist[addr];
        if (mq.size() == 16) begin
          gw = 0;
          foreach (mq[i]) gw = (gw << 2) | {30'b0, mq[i]};
          exp_dout = m_g2b(gw);
          exp_dv = 1;
          mhist[mw] = exp_dout;
          mw = (mw + 1) % HIST_DEPTH;
          mq.delete();
          if (ss_valid) exp_fe = 1;
        end else if (ss_valid) begin
          if (ss_start) begin
            if (mq.size() != 0) exp_fe = 1;
            mq.delete();
            mq.push_back(ss);
          end else if (mq.size() != 0) begin
            mq.push_back(ss);
          end
        end
      end
      exp_busy = (mq.size() != 0);
    end
  end

  // Cycle compare on the falling edge, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      chk("dataout", dataout, exp_dout);
      chk("dout_valid", 32'(dout_valid), 32'(exp_dv));
      chk("frame_err", 32'(frame_err), 32'(exp_fe));
      chk("busy", 32'(busy), 32'(exp_busy));
      chk("rd_data", rd_data, exp_rd);
      dv_cnt += int'(dout_valid);
      fe_cnt += int'(frame_err);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic drive(input logic v, input logic st, input logic [1:0] sym,
                       input logic r, input logic [1:0] a);
    @(negedge clk);
    ss_valid = v; ss_start = st; ss = sym; rw = r; addr = a;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 2'b00, 1'b0, 2'b00);
  endtask

  task automatic send_beats(input logic [31:0] gray, input int first, input int last, input int gap);
    logic [1:0] sym;
    for (int k = first; k <= last; k++) begin
      sym = gray[31-2*k -: 2];
      drive(1'b1, k == 0, sym, 1'b0, 2'b00);
      if (gap > 0 && k < last) idle(gap);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    ss_valid = 0; ss_start = 0; rw = 0;
    reset = 1;
    @(negedge clk);
    reset = 0;
  endtask

  initial begin
    int dv0, fe0;
    logic [31:0] g1;

    chk("model_g2b_7", m_g2b(32'h7), 32'h5);
    chk("model_g2b_msb", m_g2b(32'h80000000), 32'hFFFFFFFF);
    chk("model_g2b_c", m_g2b(32'hC), 32'h8);

    repeat (2) @(negedge clk);
    reset = 0;
    chk("rst_dataout", dataout, 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_rd_data", rd_data, 32'h0);

    // Non-start beat while idle is ignored without error.
    drive(1'b1, 1'b0, 2'b11, 1'b0, 2'b00);
    idle(1);
    chk("idle_stray_busy", 32'(busy), 32'h0);
    chk("idle_stray_err", 32'(frame_err), 32'h0);

    // Contiguous frame, latency and history entry 0.
    send_beats(32'h00000007, 0, 15, 0);
    idle(1);
    chk("f7_dv_early", 32'(dout_valid), 32'h0);
    chk("f7_busy_decode", 32'(busy), 32'h1);
    idle(1);
    chk("f7_dv", 32'(dout_valid), 32'h1);
    chk("f7_data", dataout, 32'h5);
    drive(1'b0, 1'b0, 2'b00, 1'b1, 2'd0);
    chk("f7_dv_once", 32'(dout_valid), 32'h0);
    idle(1);
    chk("f7_hist0", rd_data, 32'h5);

    // Stalled frame: timing relative to last beat unchanged.
    send_beats(32'h80000000, 0, 15, 2);
    idle(1);
    chk("fmsb_dv_early", 32'(dout_valid), 32'h0);
    idle(1);
    chk("fmsb_dv", 32'(dout_valid), 32'h1);
    chk("fmsb_data", dataout, 32'hFFFFFFFF);
    idle(1);

    // Restart at beat 9 then a full frame.
    dv0 = dv_cnt; fe0 = fe_cnt;
    send_beats(32'hDEADBEEF, 0, 8, 0);
    send_beats(32'h0000000C, 0, 15, 0);
    idle(3);
    chk("restart_fe_cnt", 32'(fe_cnt - fe0), 32'h1);
    chk("restart_dv_cnt", 32'(dv_cnt - dv0), 32'h1);
    chk("restart_data", dataout, 32'h8);

    // Five frames wrap the four-entry history.
    do_reset();
    g1 = 32'h1; send_beats(g1, 0, 15, 0); idle(2);
    g1 = 32'h3; send_beats(g1, 0, 15, 0); idle(2);
    g1 = 32'h2; send_beats(g1, 0, 15, 0); idle(2);
    g1 = 32'h6; send_beats(g1, 0, 15, 0); idle(2);
    g1 = 32'h7; send_beats(g1, 0, 15, 0); idle(2);
    chk("wrap_last_data", dataout, 32'h5);
    drive(1'b0, 1'b0, 2'b00, 1'b1, 2'd0);
    drive(1'b0, 1'b0, 2'b00, 1'b1, 2'd1);
    chk("wrap_rd0", rd_data, 32'h5);
    drive(1'b0, 1'b0, 2'b00, 1'b1, 2'd2);
    chk("wrap_rd1", rd_data, 32'h2);
    drive(1'b0, 1'b0, 2'b00, 1'b1, 2'd3);
    chk("wrap_rd2", rd_data, 32'h3);
    idle(1);
    chk("wrap_rd3", rd_data, 32'h4);
    idle(1);
    chk("wrap_rd_hold", rd_data, 32'h4);

    // Reset mid-frame, then a frame starting on the first edge after release.
    dv0 = dv_cnt; fe0 = fe_cnt;
    send_beats(32'h12345678, 0, 9, 0);
    @(negedge clk);
    #2;
    ss_valid = 0; ss_start = 0;
    reset = 1;
    #1;
    chk("midrst_dataout", dataout, 32'h0);
    chk("midrst_busy", 32'(busy), 32'h0);
    chk("midrst_rd_data", rd_data, 32'h0);
    @(negedge clk);
    reset = 0;
    g1 = 32'h00000001;
    ss_valid = 1; ss_start = 1; ss = g1[31:30];
    send_beats(g1, 1, 15, 0);
    idle(1);
    chk("midrst_no_dv", 32'(dv_cnt - dv0), 32'h0);
    chk("midrst_no_fe", 32'(fe_cnt - fe0), 32'h0);
    idle(1);
    chk("midrst_dv", 32'(dout_valid), 32'h1);
    chk("midrst_data", dataout, 32'h1);
    idle(1);

    // Beat during DECODE is dropped; same-edge read of the entry being written returns old value.
    dv0 = dv_cnt; fe0 = fe_cnt;
    send_beats(32'h0000000F, 0, 15, 0);
    drive(1'b1, 1'b1, 2'b01, 1'b1, 2'd1);
    drive(1'b0, 1'b0, 2'b00, 1'b1, 2'd1);
    chk("drop_fe", 32'(frame_err), 32'h1);
    chk("drop_dv", 32'(dout_valid), 32'h1);
    chk("drop_data", dataout, 32'hA);
    chk("drop_rbw_old", rd_data, 32'h0);
    chk("drop_no_frame", 32'(busy), 32'h0);
    idle(1);
    chk("drop_rbw_new", rd_data, 32'hA);
    chk("drop_fe_once", 32'(frame_err), 32'h0);
    idle(2);
    chk("drop_fe_cnt", 32'(fe_cnt - fe0), 32'h1);
    chk("drop_dv_cnt", 32'(dv_cnt - dv0), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
